// File: rtl/mips16_pkg.sv
// Shared constants and types for the mips16 core: ALU opcodes and the
// multiply/divide sequencer state encoding.
`timescale 1ns/1ps
package mips16_pkg;

  localparam int MD_WIDTH = 16;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;
  localparam logic [2:0] ALU_SRL   = 3'b110;
  localparam logic [2:0] ALU_SLL   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_carry.sv
// Recovers the carry-out (add) or borrow-out (subtract) of a 16-bit ALU
// operation from the operand and result sign bits alone, since the shared
// ALU does not export its carry chain.
`timescale 1ns/1ps
module md_carry (
  input  logic a15,
  input  logic b15,
  input  logic r15,
  input  logic sub,
  output logic flag
);

  logic carry;
  logic borrow;

  assign carry  = (a15 & b15) | ((a15 | b15) & ~r15);
  assign borrow = (~a15 & b15) | (~(a15 ^ b15) & r15);
  assign flag   = sub ? borrow : carry;

endmodule

// File: rtl/mul_div_seq.sv
// Multi-cycle unsigned 16x16 multiply / 16/16 restoring divide sequencer.
// While busy it borrows the core ALU for one add or subtract per cycle;
// shifting and carry/borrow recovery are done locally.
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1; op_div/op_a/op_b are sampled on that same edge only. start while
// ready=0 is dropped (no queueing). done pulses for one cycle when hi/lo
// are final; hi/lo/div0 then hold until the next accepted start.
`timescale 1ns/1ps
module mul_div_seq
  import mips16_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  output logic [3:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_result,
  output md_state_t        state
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  logic [WIDTH-1:0] opnd;     // multiplicand in MUL, divisor in DIV
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shifted;  // divide: partial remainder shifted left by one
  logic             flag;
  logic             ge;

  assign ready     = (state == MD_IDLE);
  assign busy      = (state == MD_MUL) || (state == MD_DIV);
  assign done      = (state == MD_DONE);
  assign alu_shamt = 4'd0;

  assign shifted = {hi[WIDTH-2:0], lo[WIDTH-1]};
  // The bit shifted out of hi is a 17th remainder bit: if set, the shifted
  // remainder certainly exceeds the divisor regardless of the borrow.
  assign ge = hi[WIDTH-1] | ~flag;

  // Drive the shared ALU only while iterating; parked at ADD of zeros otherwise.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    case (state)
      MD_MUL: begin
        alu_a = hi;
        alu_b = lo[0] ? opnd : '0;
      end
      MD_DIV: begin
        alu_a    = shifted;
        alu_b    = opnd;
        alu_ctrl = ALU_SUB;
      end
      default: ;
    endcase
  end

  md_carry u_carry (
    .a15  (alu_a[WIDTH-1]),
    .b15  (alu_b[WIDTH-1]),
    .r15  (alu_result[WIDTH-1]),
    .sub  (state == MD_DIV),
    .flag (flag)
  );

  // Sequencer state, operand latch, iteration counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      opnd  <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      div0  <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            cnt <= '0;
            if (!op_div) begin
              opnd  <= op_a;
              hi    <= '0;
              lo    <= op_b;
              div0  <= 1'b0;
              state <= MD_MUL;
            end else if (op_b != '0) begin
              opnd  <= op_b;
              hi    <= '0;
              lo    <= op_a;
              div0  <= 1'b0;
              state <= MD_DIV;
            end else begin
              hi    <= op_a;
              lo    <= '1;
              div0  <= 1'b1;
              state <= MD_DONE;
            end
          end
        end
        MD_MUL: begin
          {hi, lo} <= {flag, alu_result, lo[WIDTH-1:1]};
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) state <= MD_DONE;
        end
        MD_DIV: begin
          hi    <= ge ? alu_result : shifted;
          lo    <= {lo[WIDTH-2:0], ge};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= MD_DONE;
        end
        default: begin
          state <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq: a behavioural ALU closes the loop, directed vectors
// push expected {div0,hi,lo} and done cycle into queues, a forked monitor
// pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_mul_div_seq;
  import mips16_pkg::*;

  localparam int W = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_div = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        ready, busy, done, div0;
  logic [15:0] hi, lo, alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic [3:0]  alu_shamt;
  md_state_t   state;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  logic [W-1:0] last_exp;
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_div_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_div     (op_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .div0       (div0),
    .hi         (hi),
    .lo         (lo),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_shamt  (alu_shamt),
    .alu_result (alu_result),
    .state      (state)
  );

  // behavioural core ALU
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_ADD:   alu_result = alu_a + alu_b;
      ALU_SUB:   alu_result = alu_a - alu_b;
      ALU_AND:   alu_result = alu_a & alu_b;
      ALU_OR:    alu_result = alu_a | alu_b;
      ALU_SLT:   alu_result = (alu_a < alu_b) ? 16'd1 : 16'd0;
      ALU_PASSB: alu_result = alu_b;
      ALU_SRL:   alu_result = alu_a >> alu_shamt;
      default:   alu_result = alu_a << alu_shamt;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_flags"}, {60'd0, ready, busy, done, div0}, 64'h8);
    check({tag, "_hilo"}, {32'd0, hi, lo}, 64'h0);
    check({tag, "_alu"}, {9'd0, alu_a, alu_b, alu_ctrl, alu_shamt}, 64'h0);
    check({tag, "_state"}, {62'd0, state}, {62'd0, MD_IDLE});
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [W-1:0] e;
    int           l;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check("result", {31'd0, div0, hi, lo}, {31'd0, e});
          check("done_cycle", 64'(cyc), 64'(l));
        end
      end
    end
  endtask

  // driver: present one request for one cycle and push its expectation
  task automatic issue(input logic d, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] e_hi, input logic [15:0] e_lo, input logic e_d0);
    @(negedge clk);
    op_div   = d;
    op_a     = a;
    op_b     = b;
    start    = 1'b1;
    last_exp = {e_d0, e_hi, e_lo};
    exp_q.push_back(last_exp);
    lat_q.push_back(cyc + 1 + (e_d0 ? 0 : 16));
  endtask

  // driver: follow the op to ready, optionally pulsing a stray start at cycle extra_at
  task automatic run_op(input int exp_busy, input int exp_notready, input int extra_at);
    int nb = 0;
    int nr = 0;
    bit got = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (extra_at != 0 && k == extra_at) begin
        start  = 1'b1;
        op_div = 1'b1;
        op_a   = 16'h5555;
        op_b   = 16'h0003;
      end
      if (extra_at != 0 && k == extra_at + 1) start = 1'b0;
      if (busy) nb++;
      if (ready) begin
        got = 1;
        break;
      end
      nr++;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got ready=0 expected ready within 60 cycles");
    end
    check("busy_cycles", 64'(nb), 64'(exp_busy));
    check("notready_cycles", 64'(nr), 64'(exp_notready));
    check("hold", {31'd0, div0, hi, lo}, {31'd0, last_exp});
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    issue(1'b0, 16'd7, 16'd6, 16'h0000, 16'h002A, 1'b0);       run_op(16, 17, 0);
    issue(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0); run_op(16, 17, 0);
    issue(1'b1, 16'd100, 16'd7, 16'd2, 16'd14, 1'b0);          run_op(16, 17, 0);
    issue(1'b1, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 1'b0); run_op(16, 17, 0);
    issue(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1); run_op(0, 1, 0);
    issue(1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0); run_op(16, 17, 0);
    issue(1'b1, 16'h8000, 16'd3, 16'd2, 16'h2AAA, 1'b0);       run_op(16, 17, 0);
    // stray start mid-multiply must be dropped
    issue(1'b0, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0); run_op(16, 17, 5);

    // asynchronous reset in cycle 8 of a divide
    issue(1'b1, 16'h8000, 16'd3, 16'd2, 16'h2AAA, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("mid_div_busy", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 16'd3, 16'd3, 16'h0000, 16'h0009, 1'b0);       run_op(16, 17, 0);

    repeat (4) @(negedge clk);
    check("pending_results", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
# mul_div_seq

Multi-cycle unsigned 16×16 multiply and 16÷16 divide sequencer for the mips16 core. It time-shares the core's single 16-bit ALU: while busy, it owns the ALU operand and control inputs and drives one ALU add or subtract per cycle. Carry, borrow and shifts are computed locally. Results land in HI/LO-style registers that the pipeline reads after `done`.

## Interface
Parameters:
- `WIDTH`, 16: operand width. Only 16 is supported; the parameter is present for package constants.
- `ITER`, 16: iterations per operation; equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request, sampled when `ready`=1.
- `op_div`  in  1  0 = multiply, 1 = divide; sampled with `start`.
- `op_a`  in  16  multiplicand or dividend.
- `op_b`  in  16  multiplier or divisor.
- `ready`  out  1  idle, accepts `start`.
- `busy`  out  1  sequencer owns the ALU; the pipeline's ALU input mux selects this block's drive.
- `done`  out  1  one-cycle pulse when `hi`/`lo` are valid.
- `div0`  out  1  sticky divide-by-zero flag for the last operation.
- `hi`  out  16  product[31:16] or remainder.
- `lo`  out  16  product[15:0] or quotient.
- `alu_a`  out  16  ALU operand a.
- `alu_b`  out  16  ALU operand b.
- `alu_ctrl`  out  3  ALU operation code.
- `alu_shamt`  out  4  always 0.
- `alu_result`  in  16  ALU result (combinational return).

## Operation
States: IDLE, MUL, DIV, DONE.

IDLE:
- `ready`=1.
- On `start` with `op_div`=0: load `mcand`=`op_a`, `hi`=0, `lo`=`op_b`, `cnt`=0, clear `div0`, go to MUL.
- On `start` with `op_div`=1 and `op_b`≠0: load `dvsr`=`op_b`, `hi`=0, `lo`=`op_a`, `cnt`=0, clear `div0`, go to DIV.
- On `start` with `op_div`=1 and `op_b`=0: `hi`=`op_a`, `lo`=16'hFFFF, `div0`=1, go to DONE.

MUL iteration (one per cycle):
- Drive `alu_a`=`hi`, `alu_b`= (`lo`[0] ? `mcand` : 0), `alu_ctrl`=ADD.
- Carry c = (a15&b15) | ((a15|b15) & ~r15).
- Update {`hi`,`lo`} ← {c, `alu_result`, `lo`[15:1]}.

DIV iteration (one per cycle, restoring):
- Let s = {`hi`[14:0], `lo`[15]} and m = `hi`[15].
- Drive `alu_a`=s, `alu_b`=`dvsr`, `alu_ctrl`=SUB.
- Borrow w = (~a15&b15) | (~(a15^b15) & r15); ge = m | ~w.
- If ge: `hi` ← `alu_result`; else `hi` ← s.
- `lo` ← {`lo`[14:0], ge}.

Common rules:
- `cnt` increments each iteration. On `cnt`=ITER-1, go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `hi`, `lo` and `div0` hold until the next accepted `start`.
- `start` while not `ready` is ignored; no queueing.
- `op_a`/`op_b`/`op_div` need only be valid in the `start` cycle.
- Outside MUL/DIV: `alu_a`=`alu_b`=0 and `alu_ctrl`=ADD. The pipeline ignores these because `busy`=0.

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `div0`=0, `hi`=`lo`=0, `alu_*`=0.
- Reset asserted mid-operation aborts immediately to the reset values. A partial result is never visible.
- Start accepted at edge 0:
  - `busy`=1 in cycles 1–16.
  - `done`=1 in cycle 17, with `hi`/`lo` final.
  - `ready`=1 again in cycle 18.
  - Latency is 17 cycles.
- Divide by zero: `done` in cycle 1, `busy` never asserts.
- `busy` is a registered state decode; the ALU path is combinational within the cycle. The pipeline must stall while `busy`∨`done`.
- `start` in the same cycle as DONE is ignored.

## Structure
- Shared package `mips16_pkg`:
  - ALU opcode constants: `ALU_ADD`=3'b000, `ALU_SUB`=3'b001, `ALU_AND`=3'b010, `ALU_OR`=3'b011, `ALU_SLT`=3'b100, `ALU_PASSB`=3'b101, `ALU_SRL`=3'b110, `ALU_SLL`=3'b111.
  - State enum `md_state_t`.
- Carry/borrow logic lives in one small combinational sub-module, `md_carry`, with inputs a15, b15, r15, sub and output flag.
- The top-level test bench instantiates `alu` next to this block and wires the ALU loop.

## Test plan
- Multiply 7×6 → `done` in cycle 17; `hi`=0x0000, `lo`=0x002A; `div0`=0.
- Multiply 0xFFFF×0xFFFF → `hi`=0xFFFE, `lo`=0x0001. Exercises carry on every iteration.
- Divide 100÷7 → `lo`=14, `hi`=2. Divide 0xFFFF÷0x8000 → `lo`=1, `hi`=0x7FFF. Exercises the m=1 path.
- Divide 0x1234÷0 → `done` in cycle 1; `div0`=1, `hi`=0x1234, `lo`=0xFFFF; `busy` stays 0.
- Extra `start` (different operands) pulsed at cycle 5 of a multiply → ignored; the first result is unchanged; `ready`=0 until cycle 18.
- `rst_n` low at cycle 8 of a divide → all outputs at reset values asynchronously. After release, a new 3×3 multiply gives `lo`=9.
